// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter between
//            NUM_REQ byte producers. Latches the granted byte, drives the
//            transmitter's level-held start/busy handshake, reports frame
//            completion to the owner and enforces an idle gap between frames.
// Ports    : clk, reset (async, active-low)
//            req_valid/req_data/req_ready/req_done  - requester side
//            tx_start/tx_data/tx_busy                - transmitter side
//            grant_id/active/tx_err                  - status
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 16,
    localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          req_done,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic [GW-1:0]               grant_id,
    output logic                        active,
    output logic                        tx_err
);

    localparam int TCW = $clog2(START_TIMEOUT);
    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [TCW-1:0] C_TO_LAST = TCW'(START_TIMEOUT - 1);
    localparam logic [GCW-1:0] C_GAP     = GCW'(GAP_CYCLES);
    localparam logic [GCW-1:0] C_GAP_ONE = GCW'(1);
    localparam logic [GW-1:0]  C_LAST_ID = GW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_BUSY    = 3'd2,
        S_RELEASE = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t                 state_q;
    logic [GW-1:0]          rr_q;
    logic [GW-1:0]          grant_q;
    logic [DATA_W-1:0]      tx_data_q;
    logic                   tx_start_q;
    logic                   active_q;
    logic [NUM_REQ-1:0]     req_done_q;
    logic                   tx_err_q;
    logic [TCW-1:0]         to_cnt_q;
    logic [GCW-1:0]         gap_cnt_q;

    logic                   w_found;
    logic [GW-1:0]          w_sel;

    // Circular search for the first pending requester starting at rr_q.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_sel   = GW'(idx);
            end
        end
    end

    // Accept strobe is only offered while idle; one-hot on the selected index.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && w_found) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            grant_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
            req_done_q <= '0;
            tx_err_q   <= 1'b0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
        end else begin
            req_done_q <= '0;
            tx_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        tx_data_q  <= req_data[w_sel*DATA_W +: DATA_W];
                        grant_q    <= w_sel;
                        rr_q       <= (w_sel == C_LAST_ID) ? '0 : w_sel + 1'b1;
                        to_cnt_q   <= '0;
                        tx_start_q <= 1'b1;
                        active_q   <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (tx_busy) begin
                        state_q <= S_BUSY;
                    end else if (to_cnt_q == C_TO_LAST) begin
                        // Transmitter never acknowledged: abort without done.
                        tx_err_q   <= 1'b1;
                        tx_start_q <= 1'b0;
                        state_q    <= S_RELEASE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_BUSY: begin
                    if (!tx_busy) begin
                        req_done_q[grant_q] <= 1'b1;
                        tx_start_q          <= 1'b0;
                        state_q             <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // One cycle with start low lets the transmitter return to idle.
                    active_q <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= C_GAP;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q <= C_GAP_ONE) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    tx_start_q <= 1'b0;
                    active_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;
    assign active   = active_q;
    assign req_done = req_done_q;
    assign tx_err   = tx_err_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between NUM_REQ byte producers using round-robin arbitration. For each granted byte it latches the data, drives the transmitter's level-held start/busy handshake, and reports completion to the owner. It also enforces a programmable idle gap between frames. It sits between the packet/command sources and the UART TX datapath, whose FSM accepts start, holds busy through the frame, and returns to idle only after start is released.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, byte width sent to the transmitter
GAP_CYCLES, 2, idle clk cycles enforced after start release before the next grant (0 allowed)
START_TIMEOUT, 16, max clk cycles in START waiting for tx_busy to rise before abort (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  requester i has a byte pending; held until accepted
req_data  in  NUM_REQ*DATA_W  byte of requester i at slice [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot accept strobe; byte i consumed on the edge where req_valid[i] && req_ready[i]
req_done  out  NUM_REQ  one-cycle pulse: frame for requester i fully transmitted
tx_start  out  1  start level to the transmitter
tx_data  out  DATA_W  byte to the transmitter, stable from START entry until IDLE
tx_busy  in  1  transmitter busy flag
grant_id  out  max(1,$clog2(NUM_REQ))  index of current owner; valid while active=1
active  out  1  a frame is in progress (states START, BUSY, RELEASE)
tx_err  out  1  one-cycle pulse: start timeout abort

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, rr pointer 0, tx_start=0, tx_data=0, grant_id=0, active=0, req_ready=0, req_done=0, tx_err=0, timeout and gap counters 0. Reset mid-frame drops tx_start immediately. The latched byte is discarded and no req_done is issued.
- States: IDLE, START, BUSY, RELEASE, GAP.
- IDLE:
  - Select the first i with req_valid[i]=1, searching circularly from rr pointer.
  - req_ready[i]=1, combinational from state and req_valid, one-hot. No request means req_ready=0.
  - On that edge: tx_data<=req_data slice i, grant_id<=i, rr pointer<=(i+1) mod NUM_REQ, timeout counter<=0, go START.
- START: tx_start=1, active=1.
  - tx_busy=1 goes to BUSY.
  - Otherwise the counter increments. When it reaches START_TIMEOUT-1 with tx_busy still 0: tx_err pulse that cycle, go RELEASE, no req_done.
- BUSY: tx_start=1, active=1. tx_busy=0 goes to RELEASE, with req_done[grant_id] pulsed in the same cycle.
- RELEASE: tx_start=0, active=1, exactly one cycle. Lets the transmitter leave its post-frame wait state and return to idle. Next state is GAP with gap counter<=GAP_CYCLES, or IDLE when GAP_CYCLES=0.
- GAP: tx_start=0, active=0, req_ready=0. Counter decrements and the state goes to IDLE when it reaches 1.
- Latency: req_valid rises in IDLE at cycle 0, req_ready=1 in cycle 0, tx_start=1 from cycle 1.
- Minimum spacing between consecutive tx_start rising edges is frame length + 2 + GAP_CYCLES cycles.
- Fairness: after requester i is granted, every other waiting requester is granted before i again.
- Requests arriving outside IDLE are held off (req_ready=0) and never lost.
- req_data changes after acceptance do not affect tx_data.
- A timeout abort still advances the rr pointer.
- tx_busy glitch high in IDLE/GAP/RELEASE is ignored.
- grant_id and tx_data keep their last value outside a frame.

Test Plan:
- Reset, then req_valid=4'b0001 with data 0x55 → req_ready[0] at cycle 0, tx_data=0x55, tx_start=1 at cycle 1; tx_busy high 10 cycles then low → req_done[0] pulse, tx_start low one cycle, 2 gap cycles, back to IDLE.
- req_valid=4'b1111 held, data 0xA0..0xA3 → grant order 0,1,2,3,0; tx_data matches per grant; each req_done aligns to its own tx_busy fall.
- Requester 2 held valid while 1 re-asserts after every accept → grants alternate 1,2,1,2; no starvation.
- tx_busy never rises → tx_err pulse exactly 16 cycles after START entry, no req_done, the next requester is still served afterwards.
- Assert reset in BUSY → tx_start=0 immediately; after release, state is IDLE, rr pointer 0, and the pending requester is re-granted.
- GAP_CYCLES=0 with back-to-back requests → the next tx_start rises exactly 2 cycles after the tx_busy fall.
